// File: rtl/modexp_ladder_ctrl.sv
// Montgomery-ladder modular exponentiation controller. Sequences two external
// Montgomery multipliers through start/done handshakes to compute x^e mod m over
// an explicit exponent length, in constant time per bit.
module modexp_ladder_ctrl #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  input  logic [LEN_W-1:0] lene,
  output logic             mul0_start,
  output logic             mul1_start,
  output logic [WIDTH-1:0] mul0_a,
  output logic [WIDTH-1:0] mul0_b,
  output logic [WIDTH-1:0] mul1_a,
  output logic [WIDTH-1:0] mul1_b,
  input  logic             mul0_done,
  input  logic             mul1_done,
  input  logic [WIDTH-1:0] mul0_res,
  input  logic [WIDTH-1:0] mul1_res,
  output logic             mul_clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    StIdle, StPre, StPreW, StIssue, StWait, StPost, StPostW, StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_x, w_x_d;
  logic [LEN_W-1:0] r_k, w_k_d;
  logic [LEN_W-1:0] r_lene;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_p0, r_p1;
  logic             r_d0, r_d1;
  logic [WIDTH-1:0] r_result;
  logic             r_mul_clear, w_clear_d;
  logic [WIDTH-1:0] r_mul0_a, r_mul0_b, r_mul1_a, r_mul1_b;
  logic [WIDTH-1:0] w_p0, w_p1;
  logic             w_both;
  logic             w_bit_d;

  // A product counts as available if it was captured earlier or arrives this cycle.
  assign w_p0   = mul0_done ? mul0_res : r_p0;
  assign w_p1   = mul1_done ? mul1_res : r_p1;
  assign w_both = (r_d0 | mul0_done) & (r_d1 | mul1_done);

  // Exponent bit for the next ISSUE; out-of-range indices (illegal lene) read as 0.
  assign w_bit_d = |(r_e & (WIDTH'(1) << w_k_d));

  assign mul0_start = (r_state == StPre) || (r_state == StIssue) || (r_state == StPost);
  assign mul1_start = (r_state == StIssue);
  assign busy       = (r_state != StIdle);
  assign done       = (r_state == StDone);
  assign mul_clear  = r_mul_clear;
  assign result     = r_result;
  assign mul0_a     = r_mul0_a;
  assign mul0_b     = r_mul0_b;
  assign mul1_a     = r_mul1_a;
  assign mul1_b     = r_mul1_b;

  // Next-state and ladder register update.
  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_x_d     = r_x;
    w_k_d     = r_k;
    w_clear_d = 1'b0;
    if (abort && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_clear_d = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            w_state_d = StPre;
            w_a_d     = in_r;
            w_k_d     = lene - LEN_W'(1);
          end
        end
        StPre:   w_state_d = StPreW;
        StPreW: begin
          if (mul0_done) begin
            w_x_d     = mul0_res;
            w_state_d = (r_lene == '0) ? StPost : StIssue;
          end
        end
        StIssue: w_state_d = StWait;
        StWait: begin
          if (w_both) begin
            w_a_d = w_p0;
            w_x_d = w_p1;
            if (r_k == '0) begin
              w_state_d = StPost;
            end else begin
              w_k_d     = r_k - LEN_W'(1);
              w_state_d = StIssue;
            end
          end
        end
        StPost:  w_state_d = StPostW;
        StPostW: if (mul0_done) w_state_d = StDone;
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State, ladder, latched inputs and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_x         <= '0;
      r_k         <= '0;
      r_lene      <= '0;
      r_e         <= '0;
      r_result    <= '0;
      r_mul_clear <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_a         <= w_a_d;
      r_x         <= w_x_d;
      r_k         <= w_k_d;
      r_mul_clear <= w_clear_d;
      if ((r_state == StIdle) && start) begin
        r_e    <= in_e;
        r_lene <= lene;
      end
      if ((r_state == StPostW) && (w_state_d == StDone)) r_result <= mul0_res;
    end
  end

  // Early-completion capture: flags clear on ISSUE and latch products during WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_d0 <= 1'b0;
      r_d1 <= 1'b0;
      r_p0 <= '0;
      r_p1 <= '0;
    end else if (r_state == StIssue) begin
      r_d0 <= 1'b0;
      r_d1 <= 1'b0;
    end else if (r_state == StWait) begin
      if (mul0_done) begin
        r_d0 <= 1'b1;
        r_p0 <= mul0_res;
      end
      if (mul1_done) begin
        r_d1 <= 1'b1;
        r_p1 <= mul1_res;
      end
    end
  end

  // Operands load on the edge entering a launch state and hold until the next launch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mul0_a <= '0;
      r_mul0_b <= '0;
      r_mul1_a <= '0;
      r_mul1_b <= '0;
    end else begin
      case (w_state_d)
        StPre: begin
          r_mul0_a <= in_x;
          r_mul0_b <= in_r2;
        end
        StIssue: begin
          if (w_bit_d) begin
            r_mul0_a <= w_a_d;
            r_mul0_b <= w_x_d;
            r_mul1_a <= w_x_d;
            r_mul1_b <= w_x_d;
          end else begin
            r_mul0_a <= w_a_d;
            r_mul0_b <= w_a_d;
            r_mul1_a <= w_a_d;
            r_mul1_b <= w_x_d;
          end
        end
        StPost: begin
          r_mul0_a <= w_a_d;
          r_mul0_b <= WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
